led_pattern_scheduler: RTL and testbench
========================================

// Module: led_pattern_scheduler
// PURPOSE
// Sequences the LED display datapath: picks the pattern mode (shift / flash / shift2) and RGB colour.
// It works in manual mode from pushbuttons or in an automatic timed playlist.
// Sits between the button/VIO inputs and the counter/pattern/colour-mux datapath, replacing ad-hoc button decode.
// Syncs and edge-detects buttons; advances modes on the counter's valid tick.
// PARAMETERS
// NB_BUTTON  4   number of pushbuttons (bit0 = mode/pause, bits1..3 = R/G/B select)
// NB_SEL     2   width of mode select
// NB_DWELL   8   width of dwell-count input (ticks per auto step)
// N_MODES    3   number of valid modes; legal codes 0..N_MODES-1
// PORTS
// clock           in   1          system clock
// i_reset         in   1          asynchronous, active-low reset
// i_auto          in   1          level: 1 = automatic playlist, 0 = manual
// i_tick          in   1          one-cycle valid pulse from counter block
// i_button        in   NB_BUTTON  raw (asynchronous) buttons, active-high
// i_dwell         in   NB_DWELL   ticks per auto step; 0 treated as 1
// o_mode          out  NB_SEL     pattern select to output mux (0 shift, 1 flash, 2 shift2)
// o_color         out  3          one-hot {B,G,R} colour enable
// o_leds          out  NB_BUTTON  indicators: [0] = auto running, [3:1] = o_color
// o_step          out  1          one-cycle pulse on every mode advance (manual or auto)
// BEHAVIOUR
// Reset (async, i_reset=0): state MANUAL, o_mode=0, o_color=3'b001, o_leds=4'b0010, o_step=0.
// Reset also clears the dwell counter and sync/edge flops. Reset mid-operation aborts everything immediately.
// Buttons: 2-flop synchroniser, then rising-edge detect (sync vs delayed).
// A raw rise first sampled at edge N acts at edge N+2; all outputs are registered.
// Held buttons produce exactly one event.
// Colour: rising edge on button k (k=1..3) sets o_color to one-hot bit k-1, in any state.
// Simultaneous colour edges: lowest index wins (R > G > B).
// Mode advance: o_mode <= (o_mode == N_MODES-1) ? 0 : o_mode+1. Code 3 is never produced.
// o_step pulses in the same cycle o_mode changes.
// FSM states MANUAL, AUTO, PAUSE:
//  MANUAL: button0 edge -> mode advance. i_tick is ignored.
//          i_auto=1 -> AUTO, with the dwell counter cleared to 0.
//  AUTO:   each i_tick increments the dwell counter.
//          When count+1 >= max(i_dwell,1): counter <= 0 and mode advance.
//          If that advance wraps mode to 0, colour also rotates R->G->B->R.
//          A colour-button edge in the same cycle overrides the rotation.
//          button0 edge -> PAUSE. If it coincides with the terminal tick, pause wins: no advance, counter held.
//          i_auto=0 -> MANUAL (counter cleared).
//  PAUSE:  counter and mode frozen; i_tick ignored.
//          button0 edge -> AUTO (counter kept). i_auto=0 -> MANUAL.
// i_auto deassert has priority over button0 in the same cycle.
// o_leds[0] = 1 only in AUTO.
// i_dwell is sampled live; lowering it below the current count gives an advance on the next tick.
// STRUCTURE
// Shared package led_ctrl_pkg: MODE_SHIFT=0, MODE_FLASH=1, MODE_SHIFT2=2, N_MODES, COL_R/G/B one-hot,
// and state encodings ST_MANUAL/ST_AUTO/ST_PAUSE.
// One sub-module: button_sync_edge (NB_BUTTON-wide 2-flop sync + rising-edge pulse).
// The FSM, dwell counter and output regs are in this module.
// TESTING
// Reset: hold i_reset=0 with random inputs -> o_mode=0, o_color=001, o_leds=0010, o_step=0.
//        Release, no stimulus -> outputs unchanged.
// Manual: i_auto=0, 4 separate button0 presses -> o_mode 1,2,0,1 with 4 o_step pulses.
//         A 50-cycle hold gives one event. Latency is exactly 2 edges.
// Auto: i_auto=1, i_dwell=3, 18 ticks -> mode advances at ticks 3,6,...,18 (0,1,2,0,1,2,0).
//       Colour goes 001->010 at tick 9 and ->100 at tick 18. i_dwell=0 -> advance on every tick.
// Pause collision: AUTO, i_dwell=2, button0 edge on the same cycle as the 2nd tick -> PAUSE, o_mode unchanged.
//                  Resume, one tick -> advance.
// Colour priority: buttons 2 and 3 rise together -> o_color=010.
//                  Colour press on the wrap cycle -> button colour wins.
// Async reset asserted mid-dwell in AUTO -> immediate reset values; after release, state MANUAL.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED display control path: pattern modes, colours
// and scheduler FSM states.
package led_ctrl_pkg;

    localparam logic [1:0] MODE_SHIFT  = 2'd0;
    localparam logic [1:0] MODE_FLASH  = 2'd1;
    localparam logic [1:0] MODE_SHIFT2 = 2'd2;
    localparam int         N_MODES     = 3;

    localparam logic [2:0] COL_R = 3'b001;
    localparam logic [2:0] COL_G = 3'b010;
    localparam logic [2:0] COL_B = 3'b100;

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_PAUSE  = 2'd2
    } sched_state_e;

    // R -> G -> B -> R on a one-hot {B,G,R} colour
    function automatic logic [2:0] rotate_color(input logic [2:0] color);
        return {color[1:0], color[2]};
    endfunction

endpackage

// File: rtl/led_pattern_scheduler_button_sync_edge.sv
// Two-flop synchroniser for raw pushbuttons followed by a one-cycle
// rising-edge pulse (synchronised level vs. its delayed copy).
module button_sync_edge #(
    parameter int NB = 4
) (
    input  logic          clock,
    input  logic          i_reset,
    input  logic [NB-1:0] i_raw,
    output logic [NB-1:0] o_rise
);

    logic [NB-1:0] sync1_r;
    logic [NB-1:0] sync2_r;
    logic [NB-1:0] dly_r;

    // synchroniser chain and delayed copy for edge detection
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
            dly_r   <= '0;
        end else begin
            sync1_r <= i_raw;
            sync2_r <= sync1_r;
            dly_r   <= sync2_r;
        end
    end

    assign o_rise = sync2_r & ~dly_r;

endmodule

// File: rtl/led_pattern_scheduler.sv
// Mode/colour sequencer for the LED datapath: manual button stepping or a
// timed automatic playlist driven by the counter block's valid tick.
module led_pattern_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int NB_BUTTON = 4,
    parameter int NB_SEL    = 2,
    parameter int NB_DWELL  = 8
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_auto,
    input  logic                 i_tick,
    input  logic [NB_BUTTON-1:0] i_button,
    input  logic [NB_DWELL-1:0]  i_dwell,
    output logic [NB_SEL-1:0]    o_mode,
    output logic [2:0]           o_color,
    output logic [NB_BUTTON-1:0] o_leds,
    output logic                 o_step
);

    sched_state_e          state_r;
    sched_state_e          state_s;
    logic [NB_DWELL-1:0]   cnt_r;
    logic [NB_DWELL-1:0]   cnt_s;
    logic [NB_BUTTON-1:0]  rise_s;
    logic [NB_SEL-1:0]     mode_s;
    logic [NB_SEL-1:0]     mode_adv_s;
    logic                  wrap_s;
    logic [2:0]            color_fsm_s;
    logic [2:0]            color_s;
    logic                  step_s;
    logic [NB_BUTTON-1:0]  leds_s;
    logic [NB_DWELL-1:0]   dwell_eff_s;
    logic [NB_DWELL:0]     cnt_inc_s;
    logic                  terminal_s;

    button_sync_edge #(.NB(NB_BUTTON)) u_btn (
        .clock   (clock),
        .i_reset (i_reset),
        .i_raw   (i_button),
        .o_rise  (rise_s)
    );

    assign wrap_s      = (o_mode == NB_SEL'(N_MODES - 1));
    assign mode_adv_s  = wrap_s ? '0 : o_mode + NB_SEL'(1);
    assign dwell_eff_s = (i_dwell == '0) ? NB_DWELL'(1) : i_dwell;
    assign cnt_inc_s   = {1'b0, cnt_r} + (NB_DWELL + 1)'(1);
    assign terminal_s  = (cnt_inc_s >= {1'b0, dwell_eff_s});

    // next-state, dwell counter and output computation
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        mode_s      = o_mode;
        color_fsm_s = o_color;
        step_s      = 1'b0;
        case (state_r)
            ST_MANUAL: begin
                if (i_auto) begin
                    state_s = ST_AUTO;
                    cnt_s   = '0;
                end else if (rise_s[0]) begin
                    mode_s = mode_adv_s;
                    step_s = 1'b1;
                end else begin
                    state_s = ST_MANUAL;
                end
            end
            ST_AUTO: begin
                // deassert beats pause, pause beats a terminal tick
                if (!i_auto) begin
                    state_s = ST_MANUAL;
                    cnt_s   = '0;
                end else if (rise_s[0]) begin
                    state_s = ST_PAUSE;
                end else if (i_tick && terminal_s) begin
                    cnt_s  = '0;
                    mode_s = mode_adv_s;
                    step_s = 1'b1;
                    if (wrap_s) begin
                        color_fsm_s = rotate_color(o_color);
                    end else begin
                        color_fsm_s = o_color;
                    end
                end else if (i_tick) begin
                    cnt_s = cnt_inc_s[NB_DWELL-1:0];
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_PAUSE: begin
                if (!i_auto) begin
                    state_s = ST_MANUAL;
                    cnt_s   = '0;
                end else if (rise_s[0]) begin
                    state_s = ST_AUTO;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            default: begin
                state_s = ST_MANUAL;
                cnt_s   = '0;
            end
        endcase

        // colour buttons override everything, lowest index first
        if (rise_s[1]) begin
            color_s = COL_R;
        end else if (rise_s[2]) begin
            color_s = COL_G;
        end else if (rise_s[3]) begin
            color_s = COL_B;
        end else begin
            color_s = color_fsm_s;
        end

        leds_s = NB_BUTTON'({color_s, (state_s == ST_AUTO)});
    end

    // state, counter and registered outputs
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_MANUAL;
            cnt_r   <= '0;
            o_mode  <= NB_SEL'(MODE_SHIFT);
            o_color <= COL_R;
            o_leds  <= NB_BUTTON'({COL_R, 1'b0});
            o_step  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            o_mode  <= mode_s;
            o_color <= color_s;
            o_leds  <= leds_s;
            o_step  <= step_s;
        end
    end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Scoreboard bench for led_pattern_scheduler: expected mode/colour pairs are
// queued as stimulus is driven and popped on every o_step pulse.
module tb_led_pattern_scheduler;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] color;
    } exp_t;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_auto;
    logic       i_tick;
    logic [3:0] i_button;
    logic [7:0] i_dwell;
    logic [1:0] o_mode;
    logic [2:0] o_color;
    logic [3:0] o_leds;
    logic       o_step;

    int   vec_cnt  = 0;
    int   err_cnt  = 0;
    int   step_seen = 0;
    exp_t sb_q[$];

    logic [1:0] auto_mode_tab [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [2:0] auto_col_tab  [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b100};

    always #5 clock = ~clock;

    led_pattern_scheduler dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_auto   (i_auto),
        .i_tick   (i_tick),
        .i_button (i_button),
        .i_dwell  (i_dwell),
        .o_mode   (o_mode),
        .o_color  (o_color),
        .o_leds   (o_leds),
        .o_step   (o_step)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_step(input logic [1:0] m, input logic [2:0] c);
        exp_t e;
        e.mode  = m;
        e.color = c;
        sb_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] mask);
        i_button = mask;
        cyc(3);
        i_button = 4'b0000;
        cyc(3);
    endtask

    task automatic tick();
        i_tick = 1'b1;
        cyc(1);
        i_tick = 1'b0;
        cyc(1);
    endtask

    // scoreboard consumer: every step pulse must match the oldest expectation
    always @(negedge clock) begin : monitor
        exp_t e;
        if (o_step === 1'b1) begin
            step_seen++;
            if (sb_q.size() == 0) begin
                check_eq("step_unexpected", 32'(o_step), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("step_mode", 32'(o_mode), 32'(e.mode));
                check_eq("step_color", 32'(o_color), 32'(e.color));
            end
        end
    end

    initial begin
        int s0;
        i_reset  = 1'b0;
        i_auto   = 1'b0;
        i_tick   = 1'b0;
        i_button = 4'b0000;
        i_dwell  = 8'd0;

        // reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            i_auto   = 1'($urandom);
            i_tick   = 1'($urandom);
            i_button = 4'($urandom);
            i_dwell  = 8'($urandom);
            cyc(1);
            check_eq("rst_mode", 32'(o_mode), 32'd0);
            check_eq("rst_color", 32'(o_color), 32'b001);
            check_eq("rst_leds", 32'(o_leds), 32'b0010);
            check_eq("rst_step", 32'(o_step), 32'd0);
        end
        i_auto = 1'b0; i_tick = 1'b0; i_button = 4'b0000; i_dwell = 8'd0;
        cyc(3);
        i_reset = 1'b1;
        cyc(5);
        check_eq("idle_mode", 32'(o_mode), 32'd0);
        check_eq("idle_leds", 32'(o_leds), 32'b0010);

        // manual press with exact latency
        expect_step(2'd1, 3'b001);
        i_button = 4'b0001;
        cyc(1);
        check_eq("lat_edge_n", 32'(o_step), 32'd0);
        cyc(1);
        check_eq("lat_edge_n1", 32'(o_step), 32'd0);
        check_eq("lat_mode_n1", 32'(o_mode), 32'd0);
        cyc(1);
        check_eq("lat_edge_n2", 32'(o_step), 32'd1);
        check_eq("lat_mode_n2", 32'(o_mode), 32'd1);
        i_button = 4'b0000;
        cyc(3);
        expect_step(2'd2, 3'b001); press(4'b0001);
        tick();
        expect_step(2'd0, 3'b001); press(4'b0001);
        expect_step(2'd1, 3'b001); press(4'b0001);

        // long hold yields a single event
        expect_step(2'd2, 3'b001);
        s0 = step_seen;
        i_button = 4'b0001;
        cyc(50);
        i_button = 4'b0000;
        cyc(3);
        check_eq("hold_once", 32'(step_seen - s0), 32'd1);
        expect_step(2'd0, 3'b001); press(4'b0001);
        check_eq("manual_leds", 32'(o_leds), 32'b0010);

        // automatic playlist, dwell 3
        i_dwell = 8'd3;
        i_auto  = 1'b1;
        cyc(2);
        check_eq("auto_leds", 32'(o_leds), 32'b0011);
        for (int t = 1; t <= 18; t++) begin
            if (t % 3 == 0) expect_step(auto_mode_tab[t/3 - 1], auto_col_tab[t/3 - 1]);
            tick();
        end
        check_eq("auto_mode_end", 32'(o_mode), 32'd0);
        check_eq("auto_color_end", 32'(o_color), 32'b100);

        // dwell 0 behaves as 1
        i_dwell = 8'd0;
        expect_step(2'd1, 3'b100); tick();
        expect_step(2'd2, 3'b100); tick();
        expect_step(2'd0, 3'b001); tick();

        // pause coinciding with the terminal tick
        i_dwell = 8'd2;
        tick();
        i_button = 4'b0001;
        cyc(2);
        i_tick = 1'b1;
        cyc(1);
        i_tick = 1'b0;
        i_button = 4'b0000;
        check_eq("pause_step", 32'(o_step), 32'd0);
        check_eq("pause_mode", 32'(o_mode), 32'd0);
        check_eq("pause_leds", 32'(o_leds), 32'b0010);
        cyc(2);
        tick();
        tick();
        check_eq("pause_frozen", 32'(o_mode), 32'd0);
        press(4'b0001);
        check_eq("resume_leds", 32'(o_leds), 32'b0011);
        expect_step(2'd1, 3'b001); tick();

        // colour priority and colour-on-wrap
        press(4'b1100);
        check_eq("prio_color", 32'(o_color), 32'b010);
        check_eq("prio_leds", 32'(o_leds), 32'b0101);
        tick();
        expect_step(2'd2, 3'b010); tick();
        tick();
        expect_step(2'd0, 3'b001);
        i_button = 4'b0010;
        cyc(2);
        i_tick = 1'b1;
        cyc(1);
        i_tick = 1'b0;
        i_button = 4'b0000;
        cyc(1);
        check_eq("wrap_color", 32'(o_color), 32'b001);
        check_eq("wrap_mode", 32'(o_mode), 32'd0);

        // asynchronous reset mid-dwell
        i_dwell = 8'd1;
        expect_step(2'd1, 3'b001); tick();
        i_dwell = 8'd5;
        tick();
        tick();
        #2;
        i_reset = 1'b0;
        #1;
        check_eq("arst_mode", 32'(o_mode), 32'd0);
        check_eq("arst_color", 32'(o_color), 32'b001);
        check_eq("arst_leds", 32'(o_leds), 32'b0010);
        check_eq("arst_step", 32'(o_step), 32'd0);
        i_auto = 1'b0;
        cyc(2);
        i_reset = 1'b1;
        cyc(2);
        check_eq("post_rst_leds", 32'(o_leds), 32'b0010);
        tick();
        tick();
        check_eq("post_rst_mode", 32'(o_mode), 32'd0);

        cyc(2);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
